l1_inference_seq: RTL

Frame-level sequencer for the first-layer engine. Accepts a 64-pixel frame as a 2-bit serial stream, assembles the 128-bit flat pixel vector, and runs the start/done handshake with the layer-1 engine. It then reads the 48 stored activations out through the engine's read port and streams them to the next stage over a valid/ready interface. Loading of the next frame overlaps with streaming of the current frame's activations.

---
 rtl/l1_inference_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/l1_inference_seq.sv
// Frame sequencer for the layer-1 engine: serial pixel assembly, start/done handshake, activation streaming.
// Optional WAIT-state watchdog and sticky error flag are built only when SEQ_TIMEOUT_EN is defined.
module l1_inference_seq #(
   parameter int N_PIXELS = 64,
   parameter int N_HIDDEN = 48
`ifdef SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 4095
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pix_valid,
   input  logic [1:0]              pix_data,
   output logic                    pix_ready,
   output logic                    l1_start,
   input  logic                    l1_done,
   output logic [2*N_PIXELS-1:0]   l1_pixels_flat,
   output logic [5:0]              l1_read_addr,
   input  logic signed [1:0]       l1_read_data,
   output logic                    h_valid,
   output logic signed [1:0]       h_data,
   output logic [5:0]              h_index,
   output logic                    h_last,
   input  logic                    h_ready,
   output logic                    frame_done,
   output logic                    error
);

   localparam int PIX_W = $clog2(N_PIXELS);

`ifdef SEQ_TIMEOUT_EN
   typedef enum logic [2:0] {IDLE, START, WAIT, RELEASE, STREAM, ERR} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, WAIT, RELEASE, STREAM} state_t;
`endif

   state_t                  state, state_next;
   logic [PIX_W-1:0]        pix_cnt;
   logic                    frame_full;
   logic [5:0]              h_idx;
   logic [2*N_PIXELS-1:0]   pixels;
   logic                    pix_xfer, frame_fill, h_xfer;

   // The buffer only accepts pixels while the engine is not looking at it.
   assign pix_ready      = !frame_full && (state == IDLE || state == STREAM);
   assign pix_xfer       = pix_valid && pix_ready;
   assign frame_fill     = pix_xfer && (pix_cnt == PIX_W'(N_PIXELS - 1));
   assign l1_start       = (state == START) || (state == WAIT);
   assign h_valid        = (state == STREAM);
   assign h_xfer         = h_valid && h_ready;
   assign h_last         = h_valid && (h_idx == 6'(N_HIDDEN - 1));
   assign frame_done     = h_xfer && h_last;
   assign l1_read_addr   = h_idx;
   assign h_index        = h_idx;
   assign h_data         = l1_read_data;
   assign l1_pixels_flat = pixels;

`ifdef SEQ_TIMEOUT_EN
   localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 13) ? $clog2(TIMEOUT_CYCLES + 1) : 13;
   logic [TO_W-1:0] wait_cnt;
   logic            timeout;

   assign timeout = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign error   = (state == ERR);

   always_ff @(posedge clk) begin
      if (rst)
         wait_cnt <= '0;
      else if (state == START)
         wait_cnt <= '0;
      else if (state == WAIT)
         wait_cnt <= wait_cnt + 1'b1;
   end
`else
   assign error = 1'b0;
`endif

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (frame_full) state_next = START;
         START:   state_next = WAIT;
         WAIT: begin
            if (l1_done)
               state_next = RELEASE;
`ifdef SEQ_TIMEOUT_EN
            else if (timeout)
               state_next = ERR;
`endif
         end
         RELEASE: if (!l1_done) state_next = STREAM;
         // A frame completing in the same cycle as the last activation goes straight to START.
         STREAM:  if (frame_done) state_next = (frame_full || frame_fill) ? START : IDLE;
         default: state_next = state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pix_cnt    <= '0;
         frame_full <= 1'b0;
         h_idx      <= '0;
         pixels     <= '0;
      end else begin
         state <= state_next;
         if (pix_xfer) begin
            pixels[{pix_cnt, 1'b0} +: 2] <= pix_data;
            pix_cnt <= frame_fill ? '0 : pix_cnt + 1'b1;
         end
         if (frame_fill)
            frame_full <= 1'b1;
         else if (state == START)
            frame_full <= 1'b0;
         if (state == RELEASE && !l1_done)
            h_idx <= '0;
         else if (h_xfer)
            h_idx <= h_last ? 6'd0 : h_idx + 6'd1;
      end
   end

endmodule
